// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator status codes, glyph codes and segment constants
package calc_pkg;

    typedef enum logic [1:0] {
        ERRO    = 2'd0,
        PRONTA  = 2'd1,
        OCUPADA = 2'd2,
        IMPRIME = 2'd3
    } status_t;

    localparam int NUM_POS = 8;

    // Buffer entry / glyph code: {blank flag, 4-bit value}; E and r reuse the flag space
    localparam logic [4:0] BLANK   = 5'h10;
    localparam logic [4:0] GLYPH_E = 5'h11;
    localparam logic [4:0] GLYPH_R = 5'h12;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    // Digits above 9 are not displayable and are stored as blank
    function automatic logic [4:0] digit_entry(input logic [3:0] d);
        return (d > 4'd9) ? BLANK : {1'b0, d};
    endfunction

endpackage

// File: rtl/calc_display_rx_seg7_decoder.sv
// rtl/calc_display_rx_seg7_decoder.sv - glyph code to active-low 7-segment pattern
module seg7_decoder
    import calc_pkg::*;
(
    input  logic [4:0] glyph,
    output logic [6:0] seg
);

    // Pure lookup; any code without a glyph renders blank
    always_comb begin
        seg = SEG_BLANK;
        case (glyph)
            5'h00:   seg = 7'h40;
            5'h01:   seg = 7'h79;
            5'h02:   seg = 7'h24;
            5'h03:   seg = 7'h30;
            5'h04:   seg = 7'h19;
            5'h05:   seg = 7'h12;
            5'h06:   seg = 7'h02;
            5'h07:   seg = 7'h78;
            5'h08:   seg = 7'h00;
            5'h09:   seg = 7'h10;
            GLYPH_E: seg = SEG_E;
            GLYPH_R: seg = SEG_R;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_display_rx.sv
// rtl/calc_display_rx.sv - digit-stream receiver with 8-digit multiplexed 7-segment driver
module calc_display_rx
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
)(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] pos,
    input  logic [3:0] dig,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       err
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    status_t          status_q;
    status_t          prev_q;
    logic [3:0]       pos_q;
    logic [3:0]       dig_q;
    logic [4:0]       disp_buf [NUM_POS];
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       scan_idx;
    logic             new_session;
    logic             wr_en;
    logic [NUM_POS-1:0] lz_blank;
    logic             lead;
    logic [4:0]       glyph;
    logic [6:0]       seg_next;

    // Register the calculator outputs once and remember the previous status
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            status_q <= PRONTA;
            prev_q   <= PRONTA;
            pos_q    <= 4'd0;
            dig_q    <= 4'd0;
        end else begin
            status_q <= status_t'(status);
            prev_q   <= status_q;
            pos_q    <= pos;
            dig_q    <= dig;
        end
    end

    assign new_session = ((prev_q == PRONTA) || (prev_q == ERRO)) && (status_q == OCUPADA);
    assign wr_en       = (status_q == OCUPADA) && !pos_q[3];

    // Display buffer: session start wipes everything, then the same-cycle write lands on top
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_POS; i++) disp_buf[i] <= BLANK;
        end else begin
            if (new_session) begin
                for (int i = 0; i < NUM_POS; i++) disp_buf[i] <= BLANK;
            end
            if (wr_en) begin
                disp_buf[pos_q[2:0]] <= digit_entry(dig_q);
            end
        end
    end

    // Error flag follows the registered status one cycle later
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else begin
            err <= (status_q == ERRO);
        end
    end

    // Scan slot timer and position counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            scan_idx <= 3'd0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    // Leading-zero mask: a zero is hidden while everything to its left is zero or blank
    always_comb begin
        lz_blank = '0;
        lead     = 1'b1;
        for (int p = 0; p < NUM_POS; p++) begin
            if (BLANK_LZ && (p < NUM_POS - 1) && lead && (disp_buf[p] == 5'h00)) begin
                lz_blank[p] = 1'b1;
            end
            lead = lead && ((disp_buf[p] == 5'h00) || (disp_buf[p] == BLANK));
        end
    end

    // Choose the glyph for the current slot; error mode hides the buffer behind "Err"
    always_comb begin
        glyph = disp_buf[scan_idx];
        if (err) begin
            if (scan_idx == 3'd5)
                glyph = GLYPH_E;
            else if (scan_idx >= 3'd6)
                glyph = GLYPH_R;
            else
                glyph = BLANK;
        end else if (lz_blank[scan_idx]) begin
            glyph = BLANK;
        end
    end

    seg7_decoder u_seg7 (
        .glyph (glyph),
        .seg   (seg_next)
    );

    // Anode and segment outputs registered together so they never disagree
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(8'b1 << scan_idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_calc_display_rx.sv
// tb/tb_calc_display_rx.sv - randomized and directed bench against a digit-level display model
module tb_calc_display_rx;

    localparam int SD = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] status;
    logic [3:0] pos;
    logic [3:0] dig;
    logic [7:0] an1, an0;
    logic [6:0] seg1, seg0;
    logic       err1, err0;

    int errors = 0;
    int checks = 0;

    int mbuf [8];
    int mprev;
    int mlast;
    logic [6:0] cap1 [8];
    logic [6:0] cap0 [8];
    logic [7:0] seen1, seen0;

    always #5 clock = ~clock;

    calc_display_rx #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_lz (
        .clock(clock), .reset(reset), .status(status), .pos(pos), .dig(dig),
        .an(an1), .seg(seg1), .err(err1)
    );

    calc_display_rx #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nz (
        .clock(clock), .reset(reset), .status(status), .pos(pos), .dig(dig),
        .an(an0), .seg(seg0), .err(err0)
    );

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int p, input bit lz, input bit errm);
        bit lead;
        if (errm) begin
            if (p == 5) return 7'h06;
            if (p >= 6) return 7'h2F;
            return 7'h7F;
        end
        if (lz && p < 7 && mbuf[p] == 0) begin
            lead = 1;
            for (int q = 0; q < p; q++) if (mbuf[q] != 0 && mbuf[q] != -1) lead = 0;
            if (lead) return 7'h7F;
        end
        return seg_of(mbuf[p]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mbuf[i] = -1;
        mprev = 1;
        mlast = 1;
    endtask

    // One clock of calculator output; the model applies the session/write rules to it
    task automatic drive(input int st, input int p, input int d);
        status = 2'(st);
        pos    = 4'(p);
        dig    = 4'(d);
        if (st == 2 && (mprev == 1 || mprev == 0))
            for (int i = 0; i < 8; i++) mbuf[i] = -1;
        if (st == 2 && p < 8) mbuf[p] = (d > 9) ? -1 : d;
        mprev = st;
        mlast = st;
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        int s, p, d;
        s = int'(status); p = int'(pos); d = int'(dig);
        repeat (4) drive(s, p, d);
    endtask

    task automatic capture_and_check(input string name);
        bit merr;
        seen1 = 8'h00;
        seen0 = 8'h00;
        repeat (8 * SD * 2 + 2) begin
            @(negedge clock);
            for (int i = 0; i < 8; i++) begin
                if (an1 == ~(8'b1 << i)) begin cap1[i] = seg1; seen1[i] = 1'b1; end
                if (an0 == ~(8'b1 << i)) begin cap0[i] = seg0; seen0[i] = 1'b1; end
            end
        end
        merr = (mlast == 0);
        checks++;
        if (seen1 !== 8'hFF || seen0 !== 8'hFF) begin
            errors++;
            $display("FAIL %s scan_coverage: lz=%h nz=%h required ff", name, seen1, seen0);
        end
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (cap1[p] !== exp_seg(p, 1, merr)) begin
                errors++;
                $display("FAIL %s seg_lz[%0d]: got %h required %h", name, p, cap1[p], exp_seg(p, 1, merr));
            end
            checks++;
            if (cap0[p] !== exp_seg(p, 0, merr)) begin
                errors++;
                $display("FAIL %s seg_nz[%0d]: got %h required %h", name, p, cap0[p], exp_seg(p, 0, merr));
            end
        end
        checks++;
        if (err1 !== merr || err0 !== merr) begin
            errors++;
            $display("FAIL %s err: got %b/%b required %b", name, err1, err0, merr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            status = 2'($urandom_range(0, 3));
            pos    = 4'($urandom_range(0, 15));
            dig    = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (an1 !== 8'hFF || seg1 !== 7'h7F || err1 !== 1'b0 ||
                an0 !== 8'hFF || seg0 !== 7'h7F || err0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_values: an=%h seg=%h err=%b required ff 7f 0", an1, seg1, err1);
            end
        end
        @(negedge clock);
        status = 2'd1; pos = 4'd0; dig = 4'd0;
        model_reset();
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clock);
            #1;
            checks++;
            if (an1 !== ~(8'b1 << (((k - 1) / SD) % 8)) || seg1 !== 7'h7F) begin
                errors++;
                $display("FAIL scan_step[%0d]: an=%h seg=%h required %h 7f", k, an1, seg1,
                         ~(8'b1 << (((k - 1) / SD) % 8)));
            end
        end
    endtask

    task automatic test_single_digit();
        drive(1, 0, 0);
        drive(2, 0, 5);
        drive(1, 0, 5);
        settle();
        capture_and_check("single_digit");
    endtask

    task automatic test_forty_two();
        drive(1, 0, 0);
        drive(2, 7, 2);
        drive(2, 6, 4);
        for (int p = 5; p >= 0; p--) drive(2, p, 0);
        drive(1, 0, 0);
        settle();
        capture_and_check("forty_two");
    endtask

    task automatic test_new_session();
        drive(1, 0, 0);
        drive(2, 0, 9);
        drive(1, 0, 9);
        settle();
        capture_and_check("new_session");
    endtask

    task automatic test_bad_pos_dig();
        drive(2, 2, 7);
        drive(2, 9, 3);
        drive(2, 2, 12);
        drive(1, 0, 0);
        settle();
        capture_and_check("bad_pos_dig");
    endtask

    task automatic test_error_mode();
        repeat (20) drive(0, 0, 0);
        capture_and_check("error_mode");
        drive(1, 0, 0);
        settle();
        capture_and_check("error_recover");
    endtask

    task automatic test_random();
        int r, st, fin;
        for (int round = 0; round < 4; round++) begin
            repeat (30) begin
                r  = $urandom_range(0, 9);
                st = (r < 5) ? 2 : (r < 7) ? 1 : (r < 9) ? 0 : 3;
                drive(st, $urandom_range(0, 10), $urandom_range(0, 11));
            end
            r   = $urandom_range(0, 2);
            fin = (r == 0) ? 1 : (r == 1) ? 3 : 0;
            drive(fin, 0, 0);
            settle();
            capture_and_check("random");
        end
    endtask

    task automatic test_mid_reset();
        repeat (6) drive(0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (an1 !== 8'hFF || seg1 !== 7'h7F || err1 !== 1'b0 ||
            an0 !== 8'hFF || seg0 !== 7'h7F || err0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: an=%h seg=%h err=%b required ff 7f 0", an1, seg1, err1);
        end
        @(negedge clock);
        status = 2'd1; pos = 4'd0; dig = 4'd0;
        model_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (an1 !== 8'hFE) begin
            errors++;
            $display("FAIL mid_reset_first_slot: an=%h required fe", an1);
        end
        settle();
        capture_and_check("after_mid_reset");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset  = 1'b0;
        status = 2'd1;
        pos    = 4'd0;
        dig    = 4'd0;
        model_reset();
        test_reset();
        test_single_digit();
        test_forty_two();
        test_new_session();
        test_bad_pos_dig();
        test_error_mode();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_display_rx.md
Name: calc_display_rx

Overview:
- Receiving end of the calculator's status/pos/dig output interface.
- Samples the digit-write stream, holds an 8-digit display buffer and drives a time-multiplexed, active-low 8-digit 7-segment display.
- Shows "Err" when the calculator reports an error.
- Sits between the calculator core and the board display pins.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit scan slot; must be >= 1.
- BLANK_LZ, 1: 1 blanks leading zeros (positions 0..6); 0 shows all stored zeros.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- status  input  2  calculator status: 0 ERRO, 1 PRONTA, 2 OCUPADA, 3 IMPRIME.
- pos  input  4  digit position written by the calculator; 0 leftmost, 7 rightmost/least significant.
- dig  input  4  digit value, 0..9.
- an  output  8  digit enables, active-low, one-hot; an[i] selects position i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- err  output  1  high while the display is in error mode.

Behaviour:
- Reset (reset low, asynchronous):
  - buffer entries all BLANK; input registers cleared (status_q = PRONTA).
  - scan_idx = 0, div_cnt = 0.
  - an = 8'hFF, seg = 7'h7F, err = 0.
- Input stage: status, pos and dig are registered once (status_q, pos_q, dig_q); prev_q holds the previous status_q.
- Buffer: 8 entries × 5 bits (blank flag + 4-bit value).
- Write rule, evaluated each cycle:
  - Condition: status_q == OCUPADA and pos_q < 8.
  - Action: buf[pos_q] <= dig_q.
  - dig_q > 9 stores BLANK.
  - pos_q 8..15 is ignored.
  - Repeated identical writes are idempotent, so busy cycles without new digits are harmless.
- New-session clear:
  - Condition: prev_q ∈ {PRONTA, ERRO} and status_q == OCUPADA.
  - All entries are set to BLANK in that same cycle; the write of that cycle then wins at pos_q.
- PRONTA and IMPRIME: buffer holds, no writes.
- Error mode:
  - status_q == ERRO sets err = 1 the next cycle.
  - Display output is overridden: positions 5,6,7 show "E","r","r"; positions 0..4 are blank.
  - Buffer contents are retained but not displayed.
  - err clears the cycle after status_q != ERRO.
- Leading-zero blanking (BLANK_LZ = 1):
  - Position p < 7 is shown blank if buf[p] == 0 and every q < p is 0 or BLANK.
  - Position 7 always shows its value.
  - Blanking applies to the displayed output only, never to stored values.
- Scan:
  - div_cnt counts 0..SCAN_DIV-1.
  - At terminal count: div_cnt -> 0 and scan_idx increments, wrapping 7 -> 0.
  - an and seg are registered together from scan_idx and the (possibly overridden) digit. They change in the same cycle, so there is no ghosting.
- Latency: a write appears on seg no later than 1 (input register) + 1 (buffer) + 1 (output register) + 8×SCAN_DIV cycles.
- Segment codes (active-low, gfedcba):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10.
  - blank = 7F, E = 06, r = 2F.
- Reset mid-scan or mid-write: immediate return to reset values. The first scan slot after reset release is position 0.
- Simultaneous clear + write + ERRO cannot occur, since status_q has a single value per cycle.

Decomposition:
- Package calc_pkg:
  - status enum (ERRO, PRONTA, OCUPADA, IMPRIME), shared with the calculator core.
  - BLANK code.
  - 7-segment constants SEG_BLANK, SEG_E, SEG_R.
  - position count constant NUM_POS = 8.
- Sub-module seg7_decoder: combinational; 5-bit glyph code (digit, blank, E, r) -> 7-bit active-low segments; instantiated once on the scan path.

Test Plan:
- Reset low with inputs toggling -> an = FF, seg = 7F, err = 0. After release with SCAN_DIV = 2, an steps FE, FD, FB, ... every 2 cycles, seg = 7F on all positions.
- Status 1 -> 2 with pos = 0, dig = 5, then status 1 -> buf = {5, B, B, B, B, B, B, B}. During the an[0] slot seg = 12; all other slots 7F.
- Status = 2, writes pos 7..0 with digits 2,4,0,0,0,0,0,0 (result 42), then status = 1, BLANK_LZ = 1 -> an[6] shows 19, an[7] shows 24, others 7F. With BLANK_LZ = 0, positions 0..5 show 40.
- New session after the above (status 1 -> 2, pos = 0, dig = 9) -> previous 42 cleared; only an[0] shows 10.
- status = 0 for 20 cycles -> err = 1; an[5] shows 06, an[6]/an[7] show 2F, others 7F. Then status = 1 -> err = 0 and the retained buffer is displayed.
- Write with pos = 9, dig = 3 and with pos = 2, dig = 12 -> no change for pos = 9; position 2 blank for dig = 12. Reset asserted mid-slot -> an = FF within the same cycle (asynchronous).
